// File: rtl/monitor_capture_fifo.sv
// Packet-committing capture FIFO for a non-backpressurable stream tap.
// Define MONITOR_CAPTURE_STATS_EN to build the pkt_count/drop_count counters.
module monitor_capture_fifo #(
  parameter int TDATA_WIDTH = 512,
  parameter int TKEEP_WIDTH = TDATA_WIDTH/8,
  parameter int TDEST_WIDTH = 16,
  parameter int TID_WIDTH   = 16,
  parameter int DEPTH       = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [TDATA_WIDTH-1:0] in_TDATA,
  input  logic [TKEEP_WIDTH-1:0] in_TKEEP,
  input  logic [TDEST_WIDTH-1:0] in_TDEST,
  input  logic [TID_WIDTH-1:0]   in_TID,
  input  logic                   in_TVALID,
  input  logic                   in_TLAST,
  output logic [TDATA_WIDTH-1:0] out_TDATA,
  output logic [TKEEP_WIDTH-1:0] out_TKEEP,
  output logic [TDEST_WIDTH-1:0] out_TDEST,
  output logic [TID_WIDTH-1:0]   out_TID,
  output logic                   out_TVALID,
  output logic                   out_TLAST,
  input  logic                   out_TREADY,
  output logic [31:0]            pkt_count,
  output logic [31:0]            drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = TDATA_WIDTH + TKEEP_WIDTH
                    + TDEST_WIDTH + TID_WIDTH + 1;
  localparam logic [AW:0] DEPTH_P = (AW+1)'(DEPTH);

  typedef enum logic {ACCEPT, DROP} state_e;

  state_e        state_q, state_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   wr_tmp_q, wr_tmp_d;
  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] wr_entry;
  logic [EW-1:0] rd_entry;
  logic          full;
  logic          wr_en;
  logic          rd_en;

  // Full is judged against the partial packet, not only committed data
  assign full = (wr_tmp_q - rd_ptr_q) == DEPTH_P;

  assign wr_entry = {in_TDATA, in_TKEEP, in_TDEST, in_TID, in_TLAST};
  assign rd_entry = mem_q[rd_ptr_q[AW-1:0]];

  assign {out_TDATA, out_TKEEP, out_TDEST, out_TID, out_TLAST} = rd_entry;
  assign out_TVALID = rd_ptr_q != wr_ptr_q;
  assign rd_en      = out_TVALID && out_TREADY;

  always_comb begin
    state_d  = state_q;
    wr_tmp_d = wr_tmp_q;
    wr_ptr_d = wr_ptr_q;
    wr_en    = 1'b0;
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, rd_en};
    unique case (state_q)
      ACCEPT: begin
        if (in_TVALID) begin
          if (!full) begin
            wr_en    = 1'b1;
            wr_tmp_d = wr_tmp_q + 1'b1;
            if (in_TLAST) wr_ptr_d = wr_tmp_q + 1'b1;
          end else begin
            wr_tmp_d = wr_ptr_q;
            if (!in_TLAST) state_d = DROP;
          end
        end
      end
      DROP: begin
        if (in_TVALID && in_TLAST) state_d = ACCEPT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ACCEPT;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      wr_tmp_q <= '0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      wr_tmp_q <= wr_tmp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_tmp_q[AW-1:0]] <= wr_entry;
  end

`ifdef MONITOR_CAPTURE_STATS_EN
  logic [31:0] pkt_count_q, pkt_count_d;
  logic [31:0] drop_count_q, drop_count_d;
  logic        commit;
  logic        drop;

  assign commit = wr_en && in_TLAST;
  assign drop   = (state_q == ACCEPT) && in_TVALID && full;

  always_comb begin
    pkt_count_d  = pkt_count_q;
    drop_count_d = drop_count_q;
    if (commit && (pkt_count_q != 32'hFFFF_FFFF))
      pkt_count_d = pkt_count_q + 32'd1;
    if (drop && (drop_count_q != 32'hFFFF_FFFF))
      drop_count_d = drop_count_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_count_q  <= '0;
      drop_count_q <= '0;
    end else begin
      pkt_count_q  <= pkt_count_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign pkt_count  = pkt_count_q;
  assign drop_count = drop_count_q;
`else
  assign pkt_count  = '0;
  assign drop_count = '0;
`endif

endmodule
